// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO only succeeds alongside a pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: synchronised line, mid-bit sampling FSM, parity/stop checks and receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx_in,
    input  logic                        rd_strobe,
    input  logic                        err_clear,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rx_valid,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        err_overrun,
    output logic                        irq
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IW   = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bad_q, bad_d;
    logic                 sync1_q, rx_sync_q, rx_prev_q;
    logic                 err_parity_q, err_parity_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 irq_q, irq_d;

    logic mid, par_exp, par_fail, stop_fail, frame_ok;
    logic fifo_empty, fifo_full_w;

    assign mid     = (bit_cnt_q == MID);
    assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bad_d     = bad_q;
        par_fail  = 1'b0;
        stop_fail = 1'b0;
        frame_ok  = 1'b0;
        if (state_q != StIdle) begin
            bit_cnt_d = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d   = StStart;
                    bit_idx_d = '0;
                    bad_d     = 1'b0;
                end
            end
            StStart: begin
                if (mid) begin
                    if (rx_sync_q) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (mid) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? StStop : StParity;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (mid) begin
                    if (rx_sync_q != par_exp) begin
                        par_fail = 1'b1;
                        bad_d    = 1'b1;
                    end
                    state_d = StStop;
                end
            end
            StStop: begin
                if (mid) begin
                    if (!rx_sync_q) begin
                        stop_fail = 1'b1;
                        bad_d     = 1'b1;
                    end
                    // Leave for idle on the last stop sample so a new start bit is caught at once.
                    if (bit_idx_q == IW'(STOP_BITS - 1)) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
                        frame_ok  = !bad_q && rx_sync_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_parity_d  = par_fail | (err_parity_q & ~err_clear);
        err_frame_d   = stop_fail | (err_frame_q & ~err_clear);
        err_overrun_d = (frame_ok & fifo_full_w & ~rd_strobe) | (err_overrun_q & ~err_clear);
        irq_d         = ~fifo_empty | err_parity_q | err_frame_q | err_overrun_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            bad_q         <= 1'b0;
            sync1_q       <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            bad_q         <= bad_d;
            sync1_q       <= rx_in;
            rx_sync_q     <= sync1_q;
            rx_prev_q     <= rx_sync_q;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            irq_q         <= irq_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (frame_ok),
        .wdata (shift_q),
        .pop   (rd_strobe),
        .head  (rd_data),
        .count (fifo_count),
        .full  (fifo_full_w),
        .empty (fifo_empty)
    );

    assign rx_valid    = ~fifo_empty;
    assign fifo_full   = fifo_full_w;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign irq         = irq_q;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per bit, even, >=4.
REQ-003 Parameter PARITY, default PAR_NONE, one of PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 8, receive FIFO entries, power of 2, >=2.
REQ-006 clock  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 rx_in  in  1  serial line, idle high, LSB first, asynchronous to clock.
REQ-009 rd_strobe  in  1  one-cycle pulse pops the FIFO head.
REQ-010 err_clear  in  1  one-cycle pulse clears all sticky error flags.
REQ-011 rd_data  out  DATA_BITS  FIFO head (show-ahead), valid while rx_valid.
REQ-012 rx_valid  out  1  FIFO not empty.
REQ-013 fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 err_parity, err_frame, err_overrun  out  1 each  sticky error flags.
REQ-016 irq  out  1  rx_valid OR any error flag, registered.

Function
REQ-017 rx_in SHALL pass a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-018 States: IDLE, START, DATA, PARITY, STOP; one bit counter (0..CLKS_PER_BIT-1) and one bit index.
REQ-019 IDLE->START on synchronized falling edge; bit counter cleared on that edge cycle.
REQ-020 Bit k (start=0) mid-sample at cycle CLKS_PER_BIT/2 + k*CLKS_PER_BIT after the detected edge.
REQ-021 START: line high at mid-sample -> glitch, return IDLE, nothing recorded.
REQ-022 DATA: DATA_BITS samples shifted LSB first; then PARITY if PARITY!=PAR_NONE, else STOP.
REQ-023 PARITY: mismatch against even/odd over data bits SHALL set err_parity and mark frame bad.
REQ-024 STOP: each of STOP_BITS samples must be high; any low sets err_frame and marks frame bad.
REQ-025 At final stop mid-sample: good frame pushed to FIFO, state -> IDLE same cycle (next start accepted immediately).
REQ-026 Bad frames (parity or frame error) SHALL NOT be pushed.
REQ-027 Good frame with FIFO full and no same-cycle pop: byte dropped, err_overrun set, FIFO unchanged.
REQ-028 Push and pop same cycle when full: both succeed, count unchanged, no overrun.
REQ-029 rd_strobe while empty: ignored, no pointer movement, no error.
REQ-030 Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH exactly.
REQ-031 rx_valid/fifo_count update the cycle after push/pop; rd_data shows new head same cycle.
REQ-032 err_clear same cycle as a new error: error wins (flag stays set).

Reset
REQ-033 reset SHALL force state IDLE, counters 0, FIFO empty, rd_data 0, rx_valid 0, fifo_full 0, fifo_count 0, all errors 0, irq 0, synchronizer 1.
REQ-034 reset mid-frame SHALL abort the frame with no push and no error; reception resumes at next falling edge after release.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum and parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-036 FIFO SHALL be sub-module uart_sync_fifo (WIDTH, DEPTH params; push, pop, head, count, full, empty).

Verification
REQ-037 8N1, CLKS_PER_BIT=16, send 0x3B -> rx_valid rises 153 cycles after detected edge, rd_data=0x3B, no errors.
REQ-038 PAR_EVEN, send 0xA5 with wrong parity bit -> err_parity=1, irq=1, rx_valid stays 0; err_clear -> err_parity=0.
REQ-039 Stop bit driven low on 0x55 -> err_frame=1, FIFO empty; following good 0x12 received normally.
REQ-040 FIFO_DEPTH=4, send 0x01..0x05 without reads -> fifo_full=1, count=4, err_overrun=1, pops return 0x01..0x04.
REQ-041 Full FIFO, pop coincident with 5th push -> count stays 4, no overrun, final order 0x02..0x05.
REQ-042 6-cycle low glitch on rx_in -> no state beyond START, nothing pushed; reset asserted mid-frame -> all outputs at reset values.
